// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult_pkg
// Purpose : Shared types and helpers for the pipelined multiplier.
//           - stage_rec_t : one pipeline stage record (valid, mode, operands,
//                           running partial sum), sized for the widest
//                           supported operand so one type serves every WIDTH.
//           - rows_per_stage() : partial-product rows summed per stage.
//           - width_mask()     : low-bit mask helper.
//           - pp_row()         : one partial-product row, already negated
//                                when it carries negative weight.
// Revision: 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Widest operand supported; records carry this many bits and the active
  // WIDTH occupies the low bits, upper bits stay zero.
  localparam int MAX_WIDTH = 64;
  localparam int SUM_W     = 2 * MAX_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic                 sgn;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic [SUM_W-1:0]     sum;
  } stage_rec_t;

  function automatic int rows_per_stage(input int width, input int stages);
    return width / stages;
  endfunction

  // Mask with the low 'bits' bits set; bits >= SUM_W yields all ones.
  function automatic logic [SUM_W-1:0] width_mask(input int bits);
    logic [SUM_W-1:0] one;
    one = {{(SUM_W-1){1'b0}}, 1'b1};
    return (one << bits) - one;
  endfunction

  // Contribution of row i to the product, modulo 2^(2*width). The MSB row
  // in signed mode has negative weight, so it is returned already negated
  // and the caller always adds.
  function automatic logic [SUM_W-1:0] pp_row(
    input int                   i,
    input logic                 a_bit,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 sgn,
    input int                   width
  );
    logic [SUM_W-1:0]     lo;
    logic [SUM_W-1:0]     full;
    logic [SUM_W-1:0]     ext;
    logic [SUM_W-1:0]     row;
    logic [SUM_W-1:0]     one;
    logic [MAX_WIDTH-1:0] one_n;
    logic                 b_msb;
    one   = {{(SUM_W-1){1'b0}}, 1'b1};
    one_n = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    lo    = width_mask(width);
    full  = width_mask(2 * width);
    b_msb = |(b & (one_n << (width - 1)));
    ext   = {{MAX_WIDTH{1'b0}}, b} & lo;
    if (sgn && b_msb) begin
      ext = ext | ~lo;
    end
    row = (ext << i) & full;
    if (!a_bit) begin
      row = '0;
    end else if (sgn && (i == width - 1)) begin
      row = (~row + one) & full;
    end
    return row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : mult_pipe_stage
// Purpose : One summing stage of the multiplier pipeline. Adds partial-product
//           rows FIRST_ROW .. FIRST_ROW+ROWS-1 to the incoming running sum and
//           registers the updated record when the pipeline advances.
// Ports   : clk    - rising-edge clock
//           rst    - asynchronous active-high reset
//           adv_i  - pipeline advance enable (global)
//           rec_i  - record from the previous stage
//           rec_o  - registered record for the next stage
// Revision: 1.0 - initial release
// ============================================================================
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FIRST_ROW = 0,
  parameter int ROWS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv_i,
  input  stage_rec_t rec_i,
  output stage_rec_t rec_o
);

  localparam logic [SUM_W-1:0]     SUM_MASK = width_mask(2 * WIDTH);
  localparam logic [MAX_WIDTH-1:0] ONE_N    = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

  stage_rec_t rec_d;
  stage_rec_t rec_q;
  logic       a_bit;

  always_comb begin
    rec_d = rec_i;
    a_bit = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      a_bit     = |(rec_i.a & (ONE_N << (FIRST_ROW + r)));
      rec_d.sum = (rec_d.sum
                   + pp_row(FIRST_ROW + r, a_bit, rec_i.b, rec_i.sgn, WIDTH))
                  & SUM_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q <= '0;
    end else if (adv_i) begin
      rec_q <= rec_d;
    end
  end

  assign rec_o = rec_q;

endmodule
`default_nettype wire

// File: rtl/multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_pipe
// Purpose : Pipelined WIDTH x WIDTH multiplier, signed or unsigned per
//           transaction, with valid/ready handshake and global-stall
//           backpressure. Input register followed by STAGES summing stages;
//           latency STAGES+1, one product per cycle.
// Params  : WIDTH  - operand width, 2..64
//           STAGES - summing stages, must divide WIDTH
// Ports   : clk       - rising-edge clock
//           rst       - asynchronous active-high reset
//           in_valid  - operand pair present
//           in_ready  - operands accepted this cycle
//           in_signed - 1 = two's-complement operands
//           a, b      - operands (WIDTH)
//           out_valid - y holds a product
//           out_ready - consumer takes y this cycle
//           y         - full 2*WIDTH product
// Revision: 1.0 - initial release
// ============================================================================
module multiplier_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y
);

  localparam int ROWS = rows_per_stage(WIDTH, STAGES);

  logic       adv;
  stage_rec_t in_d;
  stage_rec_t in_q;
  stage_rec_t pipe [STAGES+1];
  logic       unused_tail;

  // Whole pipeline moves together; a stalled output freezes every stage,
  // bubbles included.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Input register: since in_ready == adv, valid here is in_valid && in_ready.
  always_comb begin
    in_d = in_q;
    if (adv) begin
      in_d.valid = in_valid;
      in_d.sgn   = in_signed;
      in_d.a     = MAX_WIDTH'(a);
      in_d.b     = MAX_WIDTH'(b);
      in_d.sum   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= '0;
    end else begin
      in_q <= in_d;
    end
  end

  assign pipe[0] = in_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mult_pipe_stage #(
      .WIDTH    (WIDTH),
      .FIRST_ROW(k * ROWS),
      .ROWS     (ROWS)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .adv_i(adv),
      .rec_i(pipe[k]),
      .rec_o(pipe[k+1])
    );
  end

  assign out_valid = pipe[STAGES].valid;
  assign y         = pipe[STAGES].sum[2*WIDTH-1:0];

  // Operands and mode are not needed past the last stage.
  assign unused_tail = ^{pipe[STAGES].sgn, pipe[STAGES].a,
                         pipe[STAGES].b, pipe[STAGES].sum};

endmodule
`default_nettype wire

// File: tb/tb_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiplier_pipe
// Purpose : Self-checking bench. Four multiplier instances, (WIDTH,STAGES) =
//           (16,4), (8,1), (8,8), (32,4), share clk/rst. Directed tests drive
//           instance 0; a randomized sweep drives all four. A reference
//           model (plain extended-precision multiply) plus a per-instance
//           queue checks products, ordering, latency and hold-under-stall.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multiplier_pipe;

  localparam int NDUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NDUT-1:0]   iv;
  logic [NDUT-1:0]   isg;
  logic [NDUT-1:0]   ordy;
  logic [NDUT-1:0]   ir;
  logic [NDUT-1:0]   ov;
  logic [63:0]       av [NDUT];
  logic [63:0]       bv [NDUT];
  logic [31:0]       y0;
  logic [15:0]       y1;
  logic [15:0]       y2;
  logic [63:0]       y3;

  typedef struct {
    logic [127:0] exp;
    int           acc;
    int           stl;
  } item_t;

  item_t        sbq [NDUT][$];
  int           stalls   [NDUT];
  bit           seen     [NDUT];
  bit           held     [NDUT];
  logic [127:0] held_y   [NDUT];
  int           accepted [NDUT];
  int           cyc;
  int           vectors;
  int           miscompares;
  logic [127:0] opm;

  logic [15:0]  ca [3] = '{16'h8000, 16'hFFFF, 16'h8000};
  logic [15:0]  cb [3] = '{16'h8000, 16'h0001, 16'h7FFF};
  logic [31:0]  cy [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hC000_8000};

  always #5 clk = ~clk;

  multiplier_pipe #(.WIDTH(16), .STAGES(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_signed(isg[0]),
    .a(av[0][15:0]), .b(bv[0][15:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .y(y0));
  multiplier_pipe #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_signed(isg[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .y(y1));
  multiplier_pipe #(.WIDTH(8), .STAGES(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_signed(isg[2]),
    .a(av[2][7:0]), .b(bv[2][7:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .y(y2));
  multiplier_pipe #(.WIDTH(32), .STAGES(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_signed(isg[3]),
    .a(av[3][31:0]), .b(bv[3][31:0]), .out_valid(ov[3]), .out_ready(ordy[3]), .y(y3));

  function automatic int wid(input int d);
    case (d)
      0:       return 16;
      1:       return 8;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int stg(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [127:0] yv(input int d);
    case (d)
      0:       return {96'd0, y0};
      1:       return {112'd0, y1};
      2:       return {112'd0, y2};
      default: return {64'd0, y3};
    endcase
  endfunction

  function automatic logic [127:0] lmask(input int bits);
    return (128'd1 << bits) - 128'd1;
  endfunction

  // Exact product: extend operands to 128 bits (sign-extend in signed mode),
  // multiply, keep 2*w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] z,
                                           input logic sgn, input int w);
    logic [127:0] lo;
    logic [127:0] ex;
    logic [127:0] ez;
    lo = lmask(w);
    ex = {64'd0, x} & lo;
    ez = {64'd0, z} & lo;
    if (sgn && (((ex >> (w - 1)) & 128'd1) != 128'd0)) ex = ex | ~lo;
    if (sgn && (((ez >> (w - 1)) & 128'd1) != 128'd0)) ez = ez | ~lo;
    return (ex * ez) & lmask(2 * w);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++) begin
      sbq[d].delete();
      seen[d] = 1'b0;
      held[d] = 1'b0;
    end
  endtask

  // Called just after a rising edge with this cycle's inputs already driven:
  // checks handshakes and outputs of the cycle, then moves to the next one.
  task automatic step();
    item_t it;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d in_ready", d), 128'(ir[d]), 128'(!ov[d] || ordy[d]));
      if (held[d]) begin
        chk($sformatf("d%0d hold valid", d), 128'(ov[d]), 128'd1);
        chk($sformatf("d%0d hold y", d), yv(d), held_y[d]);
      end
      if (ov[d]) begin
        if (sbq[d].size() == 0) begin
          chk($sformatf("d%0d spurious out_valid", d), 128'(ov[d]), 128'd0);
        end else begin
          it = sbq[d][0];
          if (!seen[d]) begin
            chk($sformatf("d%0d latency", d), 128'(cyc - it.acc),
                128'(stg(d) + 1 + stalls[d] - it.stl));
            seen[d] = 1'b1;
          end
          if (ordy[d]) begin
            chk($sformatf("d%0d product", d), yv(d), it.exp);
            void'(sbq[d].pop_front());
            seen[d] = 1'b0;
          end
        end
      end
      held[d]   = ov[d] && !ordy[d];
      held_y[d] = yv(d);
      if (iv[d] && ir[d]) begin
        it.exp = ref_mul(av[d], bv[d], isg[d], wid(d));
        it.acc = cyc;
        it.stl = stalls[d];
        sbq[d].push_back(it);
        accepted[d]++;
      end
      if (!ir[d]) stalls[d]++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic bit sweep_done();
    for (int d = 0; d < NDUT; d++) begin
      if (accepted[d] < 1000) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int d = 0; d < NDUT; d++) n += sbq[d].size();
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    iv          = '0;
    isg         = '0;
    ordy        = '1;
    for (int d = 0; d < NDUT; d++) begin
      av[d]       = '0;
      bv[d]       = '0;
      stalls[d]   = 0;
      accepted[d] = 0;
    end
    clear_model();

    // ---- reset state -------------------------------------------------------
    rst = 1'b1;
    #12;
    chk("reset out_valid", 128'(ov[0]), 128'd0);
    chk("reset y", yv(0), 128'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d post-reset in_ready", d), 128'(ir[d]), 128'd1);
      chk($sformatf("d%0d post-reset out_valid", d), 128'(ov[d]), 128'd0);
    end

    // ---- single unsigned op: latency 5, one-cycle pulse --------------------
    iv[0] = 1'b1; isg[0] = 1'b0; av[0] = 64'hFFFF; bv[0] = 64'hFFFF;
    step();
    iv[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("t1 early out_valid", 128'(ov[0]), 128'd0);
      step();
    end
    chk("t1 out_valid", 128'(ov[0]), 128'd1);
    chk("t1 y", yv(0), 128'hFFFE_0001);
    step();
    chk("t1 pulse end", 128'(ov[0]), 128'd0);

    // ---- signed corners back to back ---------------------------------------
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; isg[0] = 1'b1; av[0] = 64'(ca[i]); bv[0] = 64'(cb[i]);
      step();
    end
    iv[0] = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t2 out_valid", 128'(ov[0]), 128'd1);
      chk("t2 y", yv(0), 128'(cy[i]));
      step();
    end
    chk("t2 end", 128'(ov[0]), 128'd0);

    // ---- mixed modes in flight ---------------------------------------------
    for (int i = 0; i < 13; i++) begin
      if (i < 8) begin
        iv[0] = 1'b1; isg[0] = (i % 2 == 0); av[0] = 64'hFFFF; bv[0] = 64'hFFFF;
      end else begin
        iv[0] = 1'b0;
      end
      if (i >= 5) begin
        chk("t3 out_valid", 128'(ov[0]), 128'd1);
        chk("t3 y", yv(0), ((i - 5) % 2 == 0) ? 128'h1 : 128'hFFFE_0001);
      end
      step();
    end
    chk("t3 end", 128'(ov[0]), 128'd0);

    // ---- backpressure: 6 items, 4-cycle stall mid-stream -------------------
    for (int i = 0; i < 20; i++) begin
      iv[0]   = (i < 6);
      isg[0]  = 1'($urandom_range(0, 1));
      av[0]   = 64'($urandom_range(0, 65535));
      bv[0]   = 64'($urandom_range(0, 65535));
      ordy[0] = !(i >= 6 && i < 10);
      if (i >= 6 && i < 10) begin
        #1;
        chk("t4 in_ready stall", 128'(ir[0]), 128'd0);
        chk("t4 out_valid stall", 128'(ov[0]), 128'd1);
      end
      step();
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    chk("t4 all delivered", 128'(sbq[0].size()), 128'd0);

    // ---- asynchronous reset with three items in flight ---------------------
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; isg[0] = 1'b0;
      av[0] = 64'($urandom_range(1, 65535));
      bv[0] = 64'($urandom_range(1, 65535));
      step();
    end
    iv[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5 reset out_valid", 128'(ov[0]), 128'd0);
    chk("t5 reset y", yv(0), 128'd0);
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t5 in_ready after reset", 128'(ir[0]), 128'd1);
    for (int i = 0; i < 10; i++) begin
      chk("t5 no output after reset", 128'(ov[0]), 128'd0);
      step();
    end

    // ---- randomized sweep across all instances -----------------------------
    for (int d = 0; d < NDUT; d++) accepted[d] = 0;
    for (int c = 0; c < 20000 && !sweep_done(); c++) begin
      for (int d = 0; d < NDUT; d++) begin
        opm     = lmask(wid(d));
        iv[d]   = (accepted[d] < 1000) && ($urandom_range(0, 3) != 0);
        isg[d]  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0:       av[d] = opm[63:0];
          1:       av[d] = opm[63:0] ^ (opm[63:0] >> 1);
          default: av[d] = {$urandom, $urandom} & opm[63:0];
        endcase
        case ($urandom_range(0, 7))
          0:       bv[d] = opm[63:0];
          1:       bv[d] = opm[63:0] ^ (opm[63:0] >> 1);
          default: bv[d] = {$urandom, $urandom} & opm[63:0];
        endcase
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    iv   = '0;
    ordy = '1;
    for (int c = 0; c < 40 && pending() != 0; c++) step();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d sweep accepted", d), 128'(accepted[d] >= 1000), 128'd1);
      chk($sformatf("d%0d sweep drained", d), 128'(sbq[d].size()), 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplier_pipe.md
Name: multiplier_pipe

Overview:
- Parametrised successor to the fixed 16-bit array multiplier.
- Generic width, a configurable number of pipeline cuts through the partial-product chain, a per-transaction signed/unsigned mode, and a valid/ready handshake with backpressure.
- Sits between producer datapaths (filters, MAC units) and consumers that may stall.
- One product per cycle at full throughput.

Parameters:
- WIDTH, 16, operand width in bits; result is 2*WIDTH. Legal range 2..64.
- STAGES, 4, number of registered partial-product groups. Must divide WIDTH; 1 <= STAGES <= WIDTH.
- ROWS, WIDTH/STAGES, derived constant: partial-product rows summed per stage. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operands this cycle
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- out_valid  out  1  y holds a valid product
- out_ready  in  1  consumer accepts y this cycle
- y  out  2*WIDTH  product, full width, no truncation

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset: all valid bits cleared; out_valid=0, y=0, internal data registers=0. in_ready=1 from the first cycle after rst deasserts.
- Advance condition: adv = !out_valid || out_ready. When adv=1, every stage shifts one step. When adv=0, all stages hold (global stall; bubbles are not collapsed).
- in_ready = adv, purely combinational from out_valid/out_ready. An operand pair is accepted when in_valid && in_ready.
- Stage 0 is the input register. It captures a, b, in_signed and valid=in_valid&&in_ready.
- Stages 1..STAGES: stage k adds rows (k-1)*ROWS .. k*ROWS-1 to the running sum from stage k-1, then registers the sum, a, b, signed flag and valid.
- Stage STAGES drives y and out_valid.
- Latency: STAGES+1 cycles from acceptance to out_valid, absent stalls. Throughput is 1 per cycle while out_ready=1.
- Row i formation:
  - If a[i]=0: row is zero.
  - Unsigned: row = zero-extended b << i.
  - Signed: row = sign-extended (2*WIDTH) b << i.
  - Signed mode, i=WIDTH-1: the row is subtracted instead of added (MSB weight of a is negative).
- All arithmetic is modulo 2^(2*WIDTH). The result equals the exact product for every operand pair in both modes.
- The mode is per transaction. Mixed signed/unsigned items in flight must not interfere.
- y holds its value while out_valid && !out_ready (stable under stall).
- When out_valid=0, y keeps its last value and carries no meaning.
- Simultaneous output pop and input accept in the same cycle are allowed; no loss, no duplication.
- in_valid=0 with adv=1 inserts a bubble (valid=0) into stage 0.
- Reset mid-operation: all in-flight items are discarded; no output pulse follows reset.
- STAGES=WIDTH gives one row per stage. STAGES=1 gives a single combinational sum stage, latency 2.

Decomposition:
- Shared package mult_pkg holds:
  - the stage-record typedef (valid, signed flag, a, b, partial sum)
  - a function computing a single partial-product row (i, a_bit, b, signed, WIDTH)
  - a localparam helper for ROWS
- Natural sub-module: mult_pipe_stage. It is parametrised by its first row index and ROWS, takes the stage record plus adv, and emits the next stage record.
- multiplier_pipe instantiates STAGES copies via generate and adds the input register and handshake logic.

Test Plan:
- Reset then single op, unsigned, WIDTH=16, STAGES=4: a=0xFFFF, b=0xFFFF, out_ready=1 -> out_valid high exactly 5 cycles after acceptance, y=0xFFFE0001, one-cycle pulse.
- Signed corners: (0x8000,0x8000)->0x40000000; (0xFFFF,0x0001)->0xFFFFFFFF; (0x8000,0x7FFF)->0xC0008000. Back-to-back with out_ready=1 -> three consecutive out_valid cycles, in order.
- Mixed mode in flight: alternate in_signed 1/0 with a=b=0xFFFF for 8 consecutive cycles -> outputs alternate 0x00000001 / 0xFFFE0001.
- Backpressure: 6 items streaming, out_ready held 0 for 4 cycles mid-stream -> in_ready=0 during the stall, y stable, no item lost or duplicated, order preserved.
- Reset mid-flight: assert rst asynchronously (between edges) with 3 items in flight -> out_valid=0 and y=0 immediately; no output in the 10 cycles after release without new input.
- Parameter sweep (WIDTH,STAGES) = (8,1), (8,8), (32,4): 1000 random operands each, both modes, random out_ready -> every y matches the reference product; latency = STAGES+1 when unstalled.
